// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD countdown timer: prescaled count steps under IDLE/RUN/PAUSED/DONE control.
// Optional feature macro: BCD_TIMER_AUTORELOAD_EN (restart from the loaded value instead of stopping at 00).
module bcd_timer_ctrl #(
    parameter int PRESCALE = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_d,
    input  logic [3:0] load_u,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] D,
    output logic [7:0] U,
    output logic       running,
    output logic       done
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t        state;
    logic [3:0]    d;
    logic [3:0]    u;
    logic [PW-1:0] presc;
    logic [3:0]    clamp_d;
    logic [3:0]    clamp_u;
    logic          step_to_zero;
`ifdef BCD_TIMER_AUTORELOAD_EN
    logic [3:0]    reload_d;
    logic [3:0]    reload_u;
    logic          reload_zero;
    logic          at_zero;
`endif

    assign clamp_d      = (load_d > 4'd9) ? 4'd9 : load_d;
    assign clamp_u      = (load_u > 4'd9) ? 4'd9 : load_u;
    assign step_to_zero = (d == 4'd0) && (u == 4'd1);
`ifdef BCD_TIMER_AUTORELOAD_EN
    assign reload_zero  = (reload_d == 4'd0) && (reload_u == 4'd0);
    assign at_zero      = (d == 4'd0) && (u == 4'd0);
`endif

    assign D = {4'b0000, d};
    assign U = {4'b0000, u};

    // Priority is load > pause > start; done is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            d        <= 4'd0;
            u        <= 4'd0;
            presc    <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reload_d <= 4'd0;
            reload_u <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                state   <= IDLE;
                d       <= clamp_d;
                u       <= clamp_u;
                presc   <= '0;
                running <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
                reload_d <= clamp_d;
                reload_u <= clamp_u;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (!pause && start) begin
                            presc <= '0;
                            if ((d != 4'd0) || (u != 4'd0)) begin
                                state   <= RUN;
                                running <= 1'b1;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state   <= PAUSED;
                            running <= 1'b0;
                        end else if (presc != PRESC_LAST) begin
                            presc <= presc + 1'b1;
                        end else begin
                            presc <= '0;
`ifdef BCD_TIMER_AUTORELOAD_EN
                            // Sitting at 00 in RUN means the previous step expired: restart.
                            if (at_zero) begin
                                d <= reload_d;
                                u <= reload_u;
                            end else
`endif
                            if (u != 4'd0) begin
                                u <= u - 4'd1;
                            end else if (d != 4'd0) begin
                                u <= 4'd9;
                                d <= d - 4'd1;
                            end
                            if (step_to_zero) begin
                                done <= 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
                                if (reload_zero) begin
                                    state   <= DONE;
                                    running <= 1'b0;
                                end
`else
                                state   <= DONE;
                                running <= 1'b0;
`endif
                            end
                        end
                    end
                    PAUSED: begin
                        if (!pause && start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
